// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: branch resolution in decode, PC redirect/flush, and I-cache miss stall.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_branch,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    input  logic [1:0]  IF_ID_prediction,
    input  logic [15:0] IF_ID_predicted_target,
    input  logic [15:0] IF_ID_PC_next,
    input  logic        hazard_stall,
    input  logic        icache_miss,
    input  logic        icache_ready,
    output logic        pc_en,
    output logic        IF_flush,
    output logic        wen_BTB,
    output logic        wen_BHT,
    output logic        update_PC,
    output logic [15:0] redirect_target,
    output logic [1:0]  state,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MISS    = 2'b01,
        FLUSH   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic   resolve, mispredicted, miscomputed;

    // Handshake: pc_en=1 means PC and IF/ID latch on this edge; a redirect
    // (update_PC) always carries IF_flush in the same cycle.
    always_comb begin
        state_d         = state_q;
        state           = state_q;
        pc_en           = 1'b0;
        IF_flush        = 1'b0;
        wen_BTB         = 1'b0;
        wen_BHT         = 1'b0;
        update_PC       = 1'b0;
        redirect_target = 16'h0000;
        resolve         = 1'b0;
        mispredicted    = (IF_ID_prediction[1] != actual_taken);
        miscomputed     = (IF_ID_predicted_target != actual_target);
        if (rst) begin
            state_d  = RUN;
            state    = RUN;
            pc_en    = 1'b1;
            IF_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    resolve   = is_branch & ~hazard_stall;
                    pc_en     = ~hazard_stall;
                    wen_BHT   = resolve & mispredicted;
                    wen_BTB   = resolve & (actual_taken | miscomputed);
                    update_PC = resolve & (mispredicted | (actual_taken & miscomputed));
                    if (update_PC) begin
                        // Redirect wins over a coincident miss: that fetch was wrong-path.
                        IF_flush        = 1'b1;
                        redirect_target = actual_taken ? actual_target : IF_ID_PC_next;
                        state_d         = FLUSH;
                    end else if (icache_miss) begin
                        state_d = MISS;
                    end
                end
                MISS: begin
                    pc_en = icache_ready;
                    if (icache_ready) state_d = RUN;
                end
                FLUSH: begin
                    pc_en    = 1'b1;
                    IF_flush = 1'b1;
                    state_d  = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] branch_q, mispredict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_q     <= 16'h0000;
            mispredict_q <= 16'h0000;
        end else begin
            if (resolve && branch_q != 16'hFFFF)
                branch_q <= branch_q + 16'h0001;
            if (update_PC && mispredict_q != 16'hFFFF)
                mispredict_q <= mispredict_q + 16'h0001;
        end
    end

    assign branch_count     = branch_q;
    assign mispredict_count = mispredict_q;
`else
    assign branch_count     = 16'h0000;
    assign mispredict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl: redirect/flush, miss stall, hazard, reset abort, counters.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        is_branch, actual_taken, hazard_stall, icache_miss, icache_ready;
    logic [15:0] actual_target, IF_ID_predicted_target, IF_ID_PC_next;
    logic [1:0]  IF_ID_prediction;
    logic        pc_en, IF_flush, wen_BTB, wen_BHT, update_PC;
    logic [15:0] redirect_target, branch_count, mispredict_count;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .is_branch(is_branch), .actual_taken(actual_taken),
        .actual_target(actual_target), .IF_ID_prediction(IF_ID_prediction),
        .IF_ID_predicted_target(IF_ID_predicted_target), .IF_ID_PC_next(IF_ID_PC_next),
        .hazard_stall(hazard_stall), .icache_miss(icache_miss), .icache_ready(icache_ready),
        .pc_en(pc_en), .IF_flush(IF_flush), .wen_BTB(wen_BTB), .wen_BHT(wen_BHT),
        .update_PC(update_PC), .redirect_target(redirect_target), .state(state),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    // Inputs change on the falling edge; outputs are sampled 2ns later.
    task automatic idle();
        @(negedge clk);
        is_branch = 0; actual_taken = 0; actual_target = 16'h0; IF_ID_prediction = 2'b00;
        IF_ID_predicted_target = 16'h0; IF_ID_PC_next = 16'h0;
        hazard_stall = 0; icache_miss = 0; icache_ready = 0;
        #2;
    endtask

    task automatic branch(input logic taken, input logic [15:0] tgt, input logic [1:0] pred,
                          input logic [15:0] ptgt, input logic [15:0] pcn);
        @(negedge clk);
        is_branch = 1; actual_taken = taken; actual_target = tgt; IF_ID_prediction = pred;
        IF_ID_predicted_target = ptgt; IF_ID_PC_next = pcn;
        hazard_stall = 0; icache_miss = 0; icache_ready = 0;
        #2;
    endtask

    task automatic test_reset();
        rst = 1;
        branch(1'b1, 16'h0010, 2'b01, 16'h0000, 16'h0002);
        branch(1'b1, 16'h0010, 2'b01, 16'h0000, 16'h0002);
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %0h exp 0", state); end
        n_checks++; if ({IF_flush, pc_en} !== 2'b11) begin n_fail++; $display("FAIL reset_flush_pcen got %b exp 11", {IF_flush, pc_en}); end
        n_checks++; if ({wen_BTB, wen_BHT, update_PC} !== 3'b000) begin n_fail++; $display("FAIL reset_writes got %b exp 000", {wen_BTB, wen_BHT, update_PC}); end
        n_checks++; if (redirect_target !== 16'h0) begin n_fail++; $display("FAIL reset_redirect got %h exp 0000", redirect_target); end
        n_checks++; if ({branch_count, mispredict_count} !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %h exp 0", {branch_count, mispredict_count}); end
        @(negedge clk); rst = 0;
        idle();
    endtask

    task automatic test_mispredict_taken();
        branch(1'b1, 16'h0010, 2'b01, 16'h0000, 16'h0002);
        n_checks++; if ({wen_BHT, wen_BTB, update_PC, IF_flush, pc_en} !== 5'b11111) begin n_fail++; $display("FAIL mpt_ctrl got %b exp 11111", {wen_BHT, wen_BTB, update_PC, IF_flush, pc_en}); end
        n_checks++; if (redirect_target !== 16'h0010) begin n_fail++; $display("FAIL mpt_target got %h exp 0010", redirect_target); end
        // Branch still presented during FLUSH must not resolve.
        branch(1'b1, 16'h0010, 2'b01, 16'h0000, 16'h0002);
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL mpt_flush_state got %0h exp 2", state); end
        n_checks++; if ({IF_flush, pc_en, wen_BHT, wen_BTB, update_PC} !== 5'b11000) begin n_fail++; $display("FAIL mpt_flush_out got %b exp 11000", {IF_flush, pc_en, wen_BHT, wen_BTB, update_PC}); end
        idle();
        n_checks++; if ({state, IF_flush, pc_en} !== 4'b0001) begin n_fail++; $display("FAIL mpt_back_run got %b exp 0001", {state, IF_flush, pc_en}); end
    endtask

    task automatic test_mispredict_not_taken();
        branch(1'b0, 16'h0030, 2'b10, 16'h0030, 16'h0006);
        n_checks++; if ({wen_BHT, wen_BTB, update_PC} !== 3'b101) begin n_fail++; $display("FAIL mpn_same_tgt got %b exp 101", {wen_BHT, wen_BTB, update_PC}); end
        n_checks++; if (redirect_target !== 16'h0006) begin n_fail++; $display("FAIL mpn_target got %h exp 0006", redirect_target); end
        idle();
        branch(1'b0, 16'h0040, 2'b10, 16'h0030, 16'h0006);
        n_checks++; if ({wen_BHT, wen_BTB, update_PC, IF_flush} !== 4'b1111) begin n_fail++; $display("FAIL mpn_diff_tgt got %b exp 1111", {wen_BHT, wen_BTB, update_PC, IF_flush}); end
        idle();
        idle();
    endtask

    task automatic test_correct_predictions();
        branch(1'b1, 16'h0020, 2'b11, 16'h0020, 16'h0008);
        n_checks++; if ({wen_BTB, wen_BHT, update_PC, IF_flush} !== 4'b1000) begin n_fail++; $display("FAIL ct_ctrl got %b exp 1000", {wen_BTB, wen_BHT, update_PC, IF_flush}); end
        n_checks++; if (redirect_target !== 16'h0) begin n_fail++; $display("FAIL ct_target got %h exp 0000", redirect_target); end
        // Correct not-taken with stale target: BTB refresh only, no redirect.
        branch(1'b0, 16'h0050, 2'b01, 16'h0020, 16'h000A);
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL ct_no_flush got %0h exp 0", state); end
        n_checks++; if ({wen_BTB, wen_BHT, update_PC} !== 3'b100) begin n_fail++; $display("FAIL cnt_ctrl got %b exp 100", {wen_BTB, wen_BHT, update_PC}); end
        branch(1'b1, 16'h0010, 2'b01, 16'h0000, 16'h0002);
        hazard_stall = 1; #1;
        n_checks++; if ({pc_en, wen_BTB, wen_BHT, update_PC, IF_flush} !== 5'b00000) begin n_fail++; $display("FAIL hazard got %b exp 00000", {pc_en, wen_BTB, wen_BHT, update_PC, IF_flush}); end
        idle();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL hazard_state got %0h exp 0", state); end
    endtask

    task automatic test_miss();
        idle(); icache_ready = 1;
        idle();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL ready_in_run got %0h exp 0", state); end
        icache_miss = 1; #1;
        n_checks++; if ({state, pc_en} !== 3'b001) begin n_fail++; $display("FAIL miss_first got %b exp 001", {state, pc_en}); end
        for (int i = 0; i < 3; i++) begin
            branch(1'b1, 16'h0010, 2'b01, 16'h0000, 16'h0002);
            icache_miss = 1; #1;
            n_checks++; if ({state, pc_en, wen_BTB, wen_BHT, update_PC} !== 6'b010000) begin n_fail++; $display("FAIL miss_hold%0d got %b exp 010000", i, {state, pc_en, wen_BTB, wen_BHT, update_PC}); end
        end
        idle(); icache_ready = 1; #1;
        n_checks++; if ({state, pc_en} !== 3'b011) begin n_fail++; $display("FAIL miss_ready got %b exp 011", {state, pc_en}); end
        idle();
        n_checks++; if ({state, pc_en} !== 3'b001) begin n_fail++; $display("FAIL miss_done got %b exp 001", {state, pc_en}); end
    endtask

    task automatic test_priority_and_reset_abort();
        branch(1'b1, 16'h0070, 2'b00, 16'h0000, 16'h0004);
        icache_miss = 1; #1;
        n_checks++; if ({update_PC, IF_flush} !== 2'b11) begin n_fail++; $display("FAIL prio_redirect got %b exp 11", {update_PC, IF_flush}); end
        idle();
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL prio_flush got %0h exp 2", state); end
        idle();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL prio_no_miss got %0h exp 0", state); end
        icache_miss = 1;
        idle();
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL abort_in_miss got %0h exp 1", state); end
        rst = 1; #1;
        n_checks++; if ({state, pc_en, IF_flush} !== 4'b0011) begin n_fail++; $display("FAIL abort_rst got %b exp 0011", {state, pc_en, IF_flush}); end
        @(negedge clk); rst = 0; #2;
        n_checks++; if ({state, pc_en, IF_flush} !== 4'b0010) begin n_fail++; $display("FAIL abort_after got %b exp 0010", {state, pc_en, IF_flush}); end
    endtask

    task automatic test_perf();
        logic [15:0] exp_b, exp_m;
`ifdef FETCH_CTRL_PERF_EN
        exp_b = 16'd5; exp_m = 16'd2;
`else
        exp_b = 16'd0; exp_m = 16'd0;
`endif
        rst = 1; idle(); rst = 0;
        branch(1'b1, 16'h0020, 2'b11, 16'h0020, 16'h0008);
        branch(1'b1, 16'h0010, 2'b01, 16'h0000, 16'h0002);
        idle();
        branch(1'b0, 16'h0020, 2'b00, 16'h0020, 16'h0008);
        branch(1'b1, 16'h0040, 2'b10, 16'h0040, 16'h0008);
        branch(1'b0, 16'h0040, 2'b10, 16'h0040, 16'h0008);
        idle();
        idle();
        n_checks++; if (branch_count !== exp_b) begin n_fail++; $display("FAIL perf_branch got %0d exp %0d", branch_count, exp_b); end
        n_checks++; if (mispredict_count !== exp_m) begin n_fail++; $display("FAIL perf_mispredict got %0d exp %0d", mispredict_count, exp_m); end
    endtask

    initial begin
        test_reset();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_correct_predictions();
        test_miss();
        test_priority_and_reset_abort();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have `clk`, input, 1: the only clock; all state updates on its rising edge.
REQ-002 SHALL have `rst`, input, 1: synchronous, active-high reset.
REQ-003 SHALL have `is_branch`, input, 1: the IF/ID instruction is a branch or jump.
REQ-004 SHALL have `actual_taken`, input, 1: decode-resolved branch direction.
REQ-005 SHALL have `actual_target`, input, 16: decode-resolved branch target.
REQ-006 SHALL have `IF_ID_prediction`, input, 2: pipelined 2-bit predictor state; bit 1 = predicted taken.
REQ-007 SHALL have `IF_ID_predicted_target`, input, 16: pipelined predicted target.
REQ-008 SHALL have `IF_ID_PC_next`, input, 16: sequential successor (PC+2) of the IF/ID instruction.
REQ-009 SHALL have `hazard_stall`, input, 1: decode load-use hazard; freeze fetch.
REQ-010 SHALL have `icache_miss`, input, 1: instruction fetch this cycle missed.
REQ-011 SHALL have `icache_ready`, input, 1: miss fill complete.
REQ-012 SHALL have `pc_en`, output, 1: drives the Fetch `stall` port (1 = PC and IF/ID advance).
REQ-013 SHALL have `IF_flush`, output, 1: drives the Fetch `clr` port and the IF/ID clear.
REQ-014 SHALL have `wen_BTB`, `wen_BHT`, `update_PC`, outputs, 1 each: predictor writes and PC redirect.
REQ-015 SHALL have `redirect_target`, output, 16: PC loaded when `update_PC`=1.
REQ-016 SHALL have `state`, output, 2: current FSM state encoding.
REQ-017 SHALL have `branch_count` and `mispredict_count`, outputs, 16 each: performance counters.

Function
REQ-018 SHALL implement FSM states RUN=2'b00, MISS=2'b01, FLUSH=2'b10; 2'b11 is illegal and SHALL return to RUN next cycle with all outputs inactive.
REQ-019 SHALL define `resolve` = `is_branch` & ~`hazard_stall` & (`state`==RUN); resolution is suppressed in MISS and FLUSH.
REQ-020 SHALL define `mispredicted` = (`IF_ID_prediction`[1] != `actual_taken`) and `miscomputed` = (`IF_ID_predicted_target` != `actual_target`).
REQ-021 SHALL assert `wen_BHT` = `resolve` & `mispredicted`, combinationally, same cycle.
REQ-022 SHALL assert `wen_BTB` = `resolve` & (`actual_taken` | `miscomputed`), combinationally.
REQ-023 SHALL assert `update_PC` = `resolve` & (`mispredicted` | (`actual_taken` & `miscomputed`)).
REQ-024 SHALL drive `redirect_target` = `actual_target` if `actual_taken`, else `IF_ID_PC_next`; it is don't-care when `update_PC`=0 and SHALL be driven 0.
REQ-025 SHALL, on `update_PC` in RUN, assert `IF_flush` in the same cycle and enter FLUSH; FLUSH lasts exactly one cycle with `pc_en`=1 and `IF_flush`=1, then returns to RUN.
REQ-026 SHALL, in RUN with `icache_miss`=1 and no `update_PC`, enter MISS; MISS holds `pc_en`=0 until `icache_ready`=1, then returns to RUN on the next edge, with `pc_en`=1 in the ready cycle.
REQ-027 SHALL, when `update_PC` and `icache_miss` coincide, give priority to the redirect: enter FLUSH and discard the miss as wrong-path.
REQ-028 SHALL, in RUN with `hazard_stall`=1, drive `pc_en`=0 and suppress all writes; otherwise `pc_en`=1 in RUN.
REQ-029 SHALL ignore `icache_ready` outside MISS, and ignore `icache_miss` in MISS and FLUSH.

Reset
REQ-030 SHALL, while `rst`=1, force `state`=RUN, `IF_flush`=1, `pc_en`=1, and drive `wen_BTB`, `wen_BHT`, `update_PC`, and `redirect_target` to 0.
REQ-031 SHALL clear both counters on `rst`; a reset asserted in MISS or FLUSH SHALL abort that state with no further stall cycles.

Configuration
REQ-032 SHALL, with `FETCH_CTRL_PERF_EN` defined, increment `branch_count` on each `resolve` and `mispredict_count` on each `update_PC`; both saturate at 16'hFFFF.
REQ-033 SHALL, without `FETCH_CTRL_PERF_EN`, tie both counters to 16'h0000 and infer no counter flops.

Verification
REQ-034 Predicted not-taken (2'b01), taken to 0x0010 -> same cycle `wen_BHT`=`wen_BTB`=`update_PC`=1, `redirect_target`=0x0010, `IF_flush`=1; next cycle FLUSH, then RUN.
REQ-035 Predicted taken (2'b10), not taken, `IF_ID_PC_next`=0x0006 -> `update_PC`=1, `redirect_target`=0x0006, `wen_BTB`=1 only if targets differ.
REQ-036 Correct taken prediction with matching target 0x0020 -> `wen_BTB`=1, `wen_BHT`=0, `update_PC`=0, no FLUSH.
REQ-037 `icache_miss` pulse, then `icache_ready` after 3 cycles -> `pc_en`=0 for 3 cycles, `state`=MISS, then RUN; a branch held meanwhile produces no writes.
REQ-038 Mispredict plus `icache_miss` in the same cycle -> FLUSH entered, MISS never entered; `rst` during MISS -> RUN with `pc_en`=1 next cycle.
REQ-039 With `FETCH_CTRL_PERF_EN` defined, 5 branches including 2 mispredicts -> `branch_count`=5 and `mispredict_count`=2; without it, both read 0.
